// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot loader that receives an instruction image over a byte stream and
// writes it into the CPU's instruction memory. The CPU is held in reset
// until the image has been loaded and its checksum has been verified.
//
// Stream layout: LEN_HI, LEN_LO (big-endian word count N), then N words of
// four bytes each (MSB first), then one checksum byte. The checksum is the
// XOR of the data bytes only.
//
// Parameter DEPTH must equal 2**ADDR_W.
//
// Ports:
//   clock       in   single rising-edge clock
//   reset       in   asynchronous active-low reset
//   restart     in   one-cycle pulse that re-arms the loader for a new image
//   rx_valid    in   byte-stream valid
//   rx_data     in   byte-stream data [7:0]
//   rx_ready    out  loader can accept a byte (LEN_HI/LEN_LO/DATA/CHK)
//   imem_we     out  one-cycle instruction-memory write strobe
//   imem_addr   out  word address of the write [ADDR_W-1:0]
//   imem_wdata  out  instruction word to write [31:0]
//   cpu_reset   out  active-low CPU reset; rises one cycle after DONE
//   done        out  image loaded and checksum correct
//   error       out  load aborted; sticky until restart or reset
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q,      state_d;
    logic [7:0]        len_hi_q,     len_hi_d;
    logic [ADDR_W-1:0] last_idx_q,   last_idx_d;
    logic [ADDR_W-1:0] word_idx_q,   word_idx_d;
    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [7:0]        chk_q,        chk_d;
    logic [31:0]       shift_q,      shift_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q,  cpu_reset_d;
    logic              done_q,       done_d;
    logic              error_q,      error_d;

    logic              accept;
    logic [15:0]       len_n;

    // The loader takes bytes in every state that still expects stream data.
    always_comb begin
        rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CHK);
    end

    // Next-state logic. Restart wins over a byte arriving in the same cycle,
    // which is simply dropped.
    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        last_idx_d   = last_idx_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        chk_d        = chk_q;
        shift_d      = shift_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        accept       = rx_valid && rx_ready;
        len_n        = {len_hi_q, rx_data};

        if (restart) begin
            state_d    = S_LEN_HI;
            word_idx_d = '0;
            byte_cnt_d = '0;
            chk_d      = '0;
            shift_d    = '0;
        end else if (accept) begin
            case (state_q)
                S_LEN_HI: begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    byte_cnt_d = '0;
                    if (len_n == 16'd0) begin
                        state_d = S_CHK;
                    end else if (len_n > 16'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        // Keep N-1 so the last word is a plain index compare;
                        // N <= DEPTH guarantees it fits in ADDR_W bits.
                        last_idx_d = ADDR_W'(len_n - 16'd1);
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    shift_d    = {shift_q[23:0], rx_data};
                    chk_d      = chk_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q;
                        imem_wdata_d = {shift_q[23:0], rx_data};
                        word_idx_d   = word_idx_q + 1'b1;
                        if (word_idx_q == last_idx_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
        // Releasing the CPU only once DONE has been held for a full cycle
        // gives the last memory write time to land first.
        cpu_reset_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LEN_HI;
            len_hi_q     <= '0;
            last_idx_q   <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            chk_q        <= '0;
            shift_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            last_idx_q   <= last_idx_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            chk_q        <= chk_d;
            shift_q      <= shift_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A behavioural model keeps the bytes
// of the current image in a queue and derives the expected status, write
// strobes and CPU reset directly from the stream layout. One compare process
// checks every DUT output against it after each rising edge; directed
// scenarios add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int ST_LOAD = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic              restart  = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;
    int gap_max = 0;

    byte unsigned      img_q[$];
    byte unsigned      stim_q[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .restart    (restart),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word count of the image held in the model, or -1 before both length bytes.
    function automatic int model_len();
        if (img_q.size() < 2) return -1;
        return int'({img_q[0], img_q[1]});
    endfunction

    // XOR of the data bytes received so far.
    function automatic logic [7:0] model_chk();
        logic [7:0] x = 8'h00;
        int n = model_len();
        for (int i = 0; i < 4 * n; i++) begin
            if (2 + i < img_q.size()) x ^= img_q[2 + i];
        end
        return x;
    endfunction

    function automatic int img_status();
        int s = img_q.size();
        int n;
        if (s < 2) return ST_LOAD;
        n = model_len();
        if (n > DEPTH) return ST_ERR;
        if (s < 3 + 4 * n) return ST_LOAD;
        return (img_q[2 + 4 * n] == model_chk()) ? ST_DONE : ST_ERR;
    endfunction

    // Compare process: update the model with what was on the inputs at the
    // edge, then check every output shortly after it.
    always begin
        int                prev_st;
        int                cur_st;
        int                s;
        int                n;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [31:0]       exp_data;
        logic              exp_cpu;
        @(posedge clock);
        prev_st  = img_status();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        if (!reset || restart) begin
            img_q.delete();
        end else if (rx_valid && prev_st == ST_LOAD) begin
            img_q.push_back(rx_data);
            s = img_q.size();
            n = model_len();
            if (s > 2 && n <= DEPTH && (s - 2) % 4 == 0) begin
                exp_we   = 1'b1;
                exp_addr = ADDR_W'((s - 2) / 4 - 1);
                exp_data = {img_q[s-4], img_q[s-3], img_q[s-2], img_q[s-1]};
            end
        end
        cur_st  = img_status();
        exp_cpu = reset && prev_st == ST_DONE && cur_st == ST_DONE;
        #1;
        if (!reset) begin
            checkOutput("rst_we",        imem_we,    0);
            checkOutput("rst_addr",      imem_addr,  0);
            checkOutput("rst_wdata",     imem_wdata, 0);
            checkOutput("rst_cpu_reset", cpu_reset,  0);
            checkOutput("rst_done",      done,       0);
            checkOutput("rst_error",     error,      0);
        end else begin
            checkOutput("rx_ready",  rx_ready,  cur_st == ST_LOAD);
            checkOutput("done",      done,      cur_st == ST_DONE);
            checkOutput("error",     error,     cur_st == ST_ERR);
            checkOutput("cpu_reset", cpu_reset, exp_cpu);
            checkOutput("imem_we",   imem_we,   exp_we);
            if (exp_we) begin
                checkOutput("imem_addr",  imem_addr,  exp_addr);
                checkOutput("imem_wdata", imem_wdata, exp_data);
            end
            if (imem_we === 1'b1) begin
                log_addr.push_back(imem_addr);
                log_data.push_back(imem_wdata);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Offer one byte after a random gap; called and returns at a falling edge.
    task automatic applyStimulus(input byte unsigned b);
        int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clock);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_stim();
        foreach (stim_q[i]) applyStimulus(stim_q[i]);
    endtask

    task automatic build_image(input int n, input bit good_chk);
        logic [7:0] x = 8'h00;
        byte unsigned b;
        stim_q.delete();
        stim_q.push_back(8'(n >> 8));
        stim_q.push_back(8'(n));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x ^= b;
                stim_q.push_back(b);
            end
            stim_q.push_back(good_chk ? x : (x ^ 8'($urandom_range(1, 255))));
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // Restart pulse, optionally with a byte offered in the same cycle.
    task automatic pulse_restart(input bit with_byte);
        restart  = 1'b1;
        rx_valid = with_byte;
        rx_data  = 8'($urandom);
        @(negedge clock);
        restart  = 1'b0;
        rx_valid = 1'b0;
        clear_log();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        clear_log();
    endtask

    initial begin
        idle(2);
        reset = 1'b1;
        idle(1);

        // Two-word image; the XOR of its eight data bytes is 0x5C.
        gap_max = 0;
        stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h01, 8'h10, 8'h40, 8'h20, 8'h5C};
        send_stim();
        idle(3);
        checkOutput("A_model_chk",    model_chk(),     8'h5C);
        checkOutput("A_model_status", img_status(),    ST_DONE);
        checkOutput("A_done",         done,            1);
        checkOutput("A_cpu_reset",    cpu_reset,       1);
        checkOutput("A_nwr",          log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            checkOutput("A_addr0", log_addr[0], 0);
            checkOutput("A_data0", log_data[0], 32'h20080005);
            checkOutput("A_addr1", log_addr[1], 1);
            checkOutput("A_data1", log_data[1], 32'h01104020);
        end

        // Same image with a wrong checksum: words still written, then error.
        pulse_restart(1'b0);
        stim_q[10] = 8'h55;
        send_stim();
        idle(3);
        checkOutput("B_error",     error,           1);
        checkOutput("B_done",      done,            0);
        checkOutput("B_cpu_reset", cpu_reset,       0);
        checkOutput("B_rx_ready",  rx_ready,        0);
        checkOutput("B_nwr",       log_addr.size(), 2);

        // Length one larger than the memory: error straight after LEN_LO.
        pulse_restart(1'b0);
        stim_q = '{8'h00, 8'h21};
        send_stim();
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        idle(3);
        rx_valid = 1'b0;
        checkOutput("C_error", error,           1);
        checkOutput("C_nwr",   log_addr.size(), 0);

        // Empty images: checksum 0x00 passes, anything else fails.
        pulse_restart(1'b0);
        stim_q = '{8'h00, 8'h00, 8'h00};
        send_stim();
        idle(2);
        checkOutput("D_done", done,            1);
        checkOutput("D_nwr",  log_addr.size(), 0);
        pulse_restart(1'b0);
        stim_q = '{8'h00, 8'h00, 8'h7F};
        send_stim();
        idle(2);
        checkOutput("E_error", error, 1);

        // Full-depth image with random gaps in rx_valid.
        pulse_restart(1'b0);
        gap_max = 3;
        build_image(DEPTH, 1'b1);
        send_stim();
        idle(3);
        checkOutput("F_done", done,            1);
        checkOutput("F_nwr",  log_addr.size(), DEPTH);
        if (log_addr.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) checkOutput("F_addr_order", log_addr[i], i);
        end

        // Reset in the middle of a load, then a fresh one-word image.
        pulse_restart(1'b0);
        gap_max = 1;
        stim_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stim();
        do_reset();
        stim_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_stim();
        idle(3);
        checkOutput("G_done", done,            1);
        checkOutput("G_nwr",  log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            checkOutput("G_addr", log_addr[0], 0);
            checkOutput("G_data", log_data[0], 32'hDEADBEEF);
        end

        // Restart from DONE with a byte offered alongside; that byte is lost.
        pulse_restart(1'b1);
        checkOutput("H_cpu_reset", cpu_reset, 0);
        checkOutput("H_done",      done,      0);
        build_image(3, 1'b1);
        send_stim();
        idle(3);
        checkOutput("H_done_again", done,            1);
        checkOutput("H_nwr",        log_addr.size(), 3);
        if (log_addr.size() == 3) checkOutput("H_addr0", log_addr[0], 0);

        // Random images, some aborted midway by a restart.
        for (int it = 0; it < 12; it++) begin
            pulse_restart($urandom_range(0, 1) == 1);
            gap_max = int'($urandom_range(0, 3));
            build_image(int'($urandom_range(0, DEPTH + 2)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0 && stim_q.size() > 3) begin
                int k = int'($urandom_range(1, stim_q.size() - 1));
                for (int i = 0; i < k; i++) applyStimulus(stim_q[i]);
                pulse_restart(1'b1);
                build_image(int'($urandom_range(0, 8)), 1'b1);
            end
            send_stim();
            idle(3);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
